// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared single-port memory with registered read data.
// Writes complete at the grant edge. Reads hold the memory for one extra cycle to return data.
module mem_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADD_S  = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [ADD_S-1:0]  req0_add,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [ADD_S-1:0]  req1_add,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic [ADD_S-1:0]  mem_add,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,

  output logic              busy
);

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [ADD_S-1:0]   addr_q, addr_d;

  logic               grant_vld;
  logic               grant_idx;
  logic               sel_wr;
  logic [ADD_S-1:0]   sel_add;
  logic [DATA_W-1:0]  sel_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  // The latched read address only matters in READ_WAIT, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // Requester selection; with both pending, the one not served last time wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state_q == IDLE && !rst && (req0_valid || req1_valid)) begin
      grant_vld = 1'b1;
      if (req0_valid && req1_valid) begin
        grant_idx = ~last_grant_q;
      end else begin
        grant_idx = req1_valid;
      end
    end
  end

  always_comb begin
    sel_wr    = grant_idx ? req1_wr    : req0_wr;
    sel_add   = grant_idx ? req1_add   : req0_add;
    sel_wdata = grant_idx ? req1_wdata : req0_wdata;
  end

  // Reset forces every output to its idle value, which also aborts any read in flight.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_rdata   = '0;
    rsp1_rdata   = '0;
    mem_add      = '0;
    mem_wr       = 1'b0;
    mem_data_in  = '0;
    busy         = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            last_grant_d = grant_idx;
            req0_ready   = ~grant_idx;
            req1_ready   = grant_idx;
            mem_add      = sel_add;
            mem_wr       = sel_wr;
            mem_data_in  = sel_wr ? sel_wdata : '0;
            if (!sel_wr) begin
              state_d = READ_WAIT;
              owner_d = grant_idx;
              addr_d  = sel_add;
            end
          end
        end
        READ_WAIT: begin
          mem_add = addr_q;
          busy    = 1'b1;
          if (owner_q) begin
            rsp1_valid = 1'b1;
            rsp1_rdata = mem_data_out;
          end else begin
            rsp0_valid = 1'b1;
            rsp0_rdata = mem_data_out;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
